match_scheduler: RTL and testbench

Front-end controller for the `matcher` block. Accepts lookup words from a requester over a valid/ready handshake and buffers them in a small FIFO. Issues the words to the matcher one at a time by driving its `cs`/`word` inputs, then returns each hit/miss result and vocabulary address over a second valid/ready channel. Sits between the tokenizer front end and the `matcher`, and is the only agent that drives the matcher's `cs`.

---
 rtl/matcher_pkg.sv | 19 +
 rtl/word_fifo.sv | 63 ++++++
 rtl/match_scheduler.sv | 171 +++++++++++++++++
 tb/tb_match_scheduler.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/matcher_pkg.sv
// Shared types and default sizing for the matcher front end.
// Used by match_scheduler and word_fifo.
package matcher_pkg;

    localparam int DEF_ADDR_WIDTH     = 4;
    localparam int DEF_WORD_LENGTH    = 3;
    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_QUEUE_DEPTH    = 4;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    typedef logic [DEF_WORD_LENGTH*DEF_DATA_WIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } sched_state_t;

endpackage

// File: rtl/word_fifo.sv
// Synchronous request FIFO with registered read pointer.
// The head entry is always visible on dout; pop advances it.
module word_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses pushes even when a pop frees a slot this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (PW+1)'(1);
                2'b01:   count_reg <= count_reg - (PW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign dout  = mem[rd_ptr_reg];
    assign full  = (count_reg == FULL_COUNT);
    assign empty = (count_reg == '0);
    assign count = count_reg;

endmodule

// File: rtl/match_scheduler.sv
// Issues buffered lookup words to the matcher one job at a time and returns results in order.
// Optional watchdog abort is enabled by defining MATCH_SCHED_TIMEOUT_EN.
module match_scheduler
    import matcher_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int WORD_LENGTH    = DEF_WORD_LENGTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int QUEUE_DEPTH    = DEF_QUEUE_DEPTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [WORD_LENGTH*DATA_WIDTH-1:0]  req_word,
    output logic                               m_cs,
    output logic [WORD_LENGTH*DATA_WIDTH-1:0]  m_word,
    input  logic                               m_done,
    input  logic                               m_hit,
    input  logic [ADDR_WIDTH-1:0]              m_addr,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic                               rsp_hit,
    output logic [ADDR_WIDTH-1:0]              rsp_addr,
    output logic                               rsp_timeout,
    output logic                               busy,
    output logic [$clog2(QUEUE_DEPTH):0]       queue_count
);

    localparam int WW = WORD_LENGTH * DATA_WIDTH;

    sched_state_t          state_reg, state_next;
    logic                  m_cs_reg, m_cs_next;
    logic [WW-1:0]         m_word_reg, m_word_next;
    logic                  rsp_valid_reg, rsp_valid_next;
    logic                  rsp_hit_reg, rsp_hit_next;
    logic [ADDR_WIDTH-1:0] rsp_addr_reg, rsp_addr_next;

    logic                  fifo_pop;
    logic [WW-1:0]         fifo_dout;
    logic                  fifo_full;
    logic                  fifo_empty;

    word_fifo #(
        .WIDTH (WW),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req_valid),
        .din   (req_word),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (queue_count)
    );

`ifdef MATCH_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_reg, wd_next;
    logic            rsp_timeout_reg, rsp_timeout_next;
`endif

    always_comb begin
        state_next     = state_reg;
        m_cs_next      = m_cs_reg;
        m_word_next    = m_word_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_hit_next   = rsp_hit_reg;
        rsp_addr_next  = rsp_addr_reg;
        fifo_pop       = 1'b0;
`ifdef MATCH_SCHED_TIMEOUT_EN
        wd_next          = wd_reg;
        rsp_timeout_next = rsp_timeout_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    m_word_next = fifo_dout;
                    m_cs_next   = 1'b1;
                    state_next  = RUN;
`ifdef MATCH_SCHED_TIMEOUT_EN
                    wd_next     = '0;
`endif
                end
            end
            RUN: begin
                // A completion on the same edge as the watchdog expiry takes priority.
                if (m_done) begin
                    rsp_hit_next   = m_hit;
                    rsp_addr_next  = m_hit ? m_addr : '0;
                    m_cs_next      = 1'b0;
                    rsp_valid_next = 1'b1;
                    state_next     = RESP;
`ifdef MATCH_SCHED_TIMEOUT_EN
                    rsp_timeout_next = 1'b0;
                end else if (wd_reg == WD_LAST) begin
                    rsp_hit_next     = 1'b0;
                    rsp_addr_next    = '0;
                    rsp_timeout_next = 1'b1;
                    m_cs_next        = 1'b0;
                    rsp_valid_next   = 1'b1;
                    state_next       = RESP;
                end else begin
                    wd_next = wd_reg + WD_W'(1);
`endif
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                m_cs_next  = 1'b0;
            end
        endcase
    end

    // m_cs comes straight from a flop cleared by reset, so it drops without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            m_cs_reg      <= 1'b0;
            m_word_reg    <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_hit_reg   <= 1'b0;
            rsp_addr_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            m_cs_reg      <= m_cs_next;
            m_word_reg    <= m_word_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_hit_reg   <= rsp_hit_next;
            rsp_addr_reg  <= rsp_addr_next;
        end
    end

`ifdef MATCH_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_reg          <= '0;
            rsp_timeout_reg <= 1'b0;
        end else begin
            wd_reg          <= wd_next;
            rsp_timeout_reg <= rsp_timeout_next;
        end
    end

    assign rsp_timeout = rsp_timeout_reg;
`else
    // Without the watchdog no job can be aborted; the compare is constant false.
    assign rsp_timeout = (TIMEOUT_CYCLES < 0);
`endif

    assign req_ready = !fifo_full;
    assign m_cs      = m_cs_reg;
    assign m_word    = m_word_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_hit   = rsp_hit_reg;
    assign rsp_addr  = rsp_addr_reg;
    assign busy      = (state_reg != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_match_scheduler.sv
// Directed bench for match_scheduler with a behavioural matcher and a response scoreboard.
// Timeout scenario runs only when MATCH_SCHED_TIMEOUT_EN is defined.
module tb_match_scheduler;
    import matcher_pkg::*;

    localparam int AW = 4;
    localparam int TO = 8;

    typedef struct {
        logic [23:0] word;
        logic        hit;
        logic [3:0]  addr;
        int          lat;     // 0 = matcher never answers
    } job_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    word_t       req_word;
    logic        m_cs;
    word_t       m_word;
    logic        m_done = 1'b0;
    logic        m_hit  = 1'b0;
    logic [3:0]  m_addr = '0;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_hit;
    logic [3:0]  rsp_addr;
    logic        rsp_timeout;
    logic        busy;
    logic [2:0]  queue_count;

    int checks = 0;
    int errors = 0;
    int n_rsp  = 0;

    job_t job_q[$];
    job_t exp_q[$];

    always #5 clk = ~clk;

    match_scheduler #(
        .ADDR_WIDTH     (AW),
        .WORD_LENGTH    (3),
        .DATA_WIDTH     (8),
        .QUEUE_DEPTH    (4),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_word    (req_word),
        .m_cs        (m_cs),
        .m_word      (m_word),
        .m_done      (m_done),
        .m_hit       (m_hit),
        .m_addr      (m_addr),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_hit     (rsp_hit),
        .rsp_addr    (rsp_addr),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .queue_count (queue_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Matcher model: answers after job.lat RUN cycles; drives junk done/hit while cs is low.
    int   run_cycles = 0;
    int   low_cnt    = 0;
    int   last_gap   = -1;
    logic was_cs     = 1'b0;
    logic seen_job   = 1'b0;
    job_t cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_done = 1'b0; was_cs = 1'b0; seen_job = 1'b0;
            low_cnt = 0; run_cycles = 0;
        end else if (m_cs) begin
            if (!was_cs) begin
                if (seen_job) last_gap = low_cnt;
                seen_job = 1'b1;
                run_cycles = 0;
                if (job_q.size() == 0) begin
                    chk("job_expected", 32'd0, 32'd1);
                    cur.word = '0; cur.hit = 1'b0; cur.addr = '0; cur.lat = 1;
                end else begin
                    cur = job_q.pop_front();
                end
            end
            run_cycles++;
            chk("m_word_stable", 32'(m_word), 32'(cur.word));
            m_done = (run_cycles == cur.lat);
            m_hit  = m_done ? cur.hit : ~cur.hit;
            m_addr = m_done ? cur.addr : ~cur.addr;
            was_cs  = 1'b1;
            low_cnt = 0;
        end else begin
            m_done = 1'b1; m_hit = 1'b1; m_addr = 4'hF;
            was_cs = 1'b0;
            low_cnt++;
        end
    end

    // Scoreboard: compare each accepted response against the oldest pushed job.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            chk("m_cs_low_in_resp", 32'(m_cs), 32'd0);
            if (rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    job_t e;
                    e = exp_q.pop_front();
                    n_rsp++;
                    $display("rsp %0d word=%06h hit=%0b addr=%0h timeout=%0b", n_rsp, e.word, rsp_hit, rsp_addr, rsp_timeout);
                    chk("rsp_hit",     32'(rsp_hit),     (e.lat == 0) ? 32'd0 : 32'(e.hit));
                    chk("rsp_addr",    32'(rsp_addr),    (e.lat == 0 || !e.hit) ? 32'd0 : 32'(e.addr));
                    chk("rsp_timeout", 32'(rsp_timeout), (e.lat == 0) ? 32'd1 : 32'd0);
                    chk("run_len",     32'(run_cycles),  (e.lat == 0) ? 32'(TO) : 32'(e.lat));
                end
            end
        end
    end

    task automatic push(input logic [23:0] w, input logic hit, input logic [3:0] addr, input int lat);
        job_t j;
        int   t = 0;
        j.word = w; j.hit = hit; j.addr = addr; j.lat = lat;
        @(negedge clk);
        while (!req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            chk("push_ready_wait", 32'd0, 32'd1);
            return;
        end
        req_valid = 1'b1;
        req_word  = w;
        job_q.push_back(j);
        exp_q.push_back(j);
        $display("push word=%06h hit=%0b addr=%0h lat=%0d", w, hit, addr, lat);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((busy || exp_q.size() != 0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_done", 32'(busy || exp_q.size() != 0), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int   base;
        logic saw_valid;

        rst_n = 1'b0; req_valid = 1'b0; req_word = '0; rsp_ready = 1'b1;
        #3;
        chk("rst_req_ready",   32'(req_ready),   32'd1);
        chk("rst_m_cs",        32'(m_cs),        32'd0);
        chk("rst_m_word",      32'(m_word),      32'd0);
        chk("rst_rsp_valid",   32'(rsp_valid),   32'd0);
        chk("rst_rsp_hit",     32'(rsp_hit),     32'd0);
        chk("rst_rsp_addr",    32'(rsp_addr),    32'd0);
        chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        chk("rst_busy",        32'(busy),        32'd0);
        chk("rst_queue_count", 32'(queue_count), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single hit on "Hel".
        push(24'h48656C, 1'b1, 4'h5, 10);
        drain();
        chk("single_rsp_count", 32'(n_rsp), 32'd1);

        // Fill and backpressure.
        @(posedge clk); #1 rsp_ready = 1'b0;
        base = n_rsp;
        push(24'h616161, 1'b1, 4'h1, 3);
        push(24'h626262, 1'b0, 4'h2, 2);
        push(24'h636363, 1'b1, 4'h3, 4);
        push(24'h646464, 1'b1, 4'h4, 1);
        push(24'h656565, 1'b0, 4'h6, 5);
        repeat (5) @(negedge clk);
        chk("full_queue_count", 32'(queue_count), 32'd4);
        chk("full_req_ready",   32'(req_ready),   32'd0);
        chk("full_rsp_valid",   32'(rsp_valid),   32'd1);
        req_valid = 1'b1; req_word = 24'h666666;
        repeat (3) @(negedge clk);
        chk("refused_queue_count", 32'(queue_count), 32'd4);
        req_valid = 1'b0;
        @(posedge clk); #1 rsp_ready = 1'b1;
        push(24'h676767, 1'b1, 4'h7, 2);
        drain();
        chk("fill_rsp_count", 32'(n_rsp - base), 32'd6);

        // Miss returns address 0.
        push(24'h78797A, 1'b0, 4'hA, 4);
        drain();

`ifdef MATCH_SCHED_TIMEOUT_EN
        // Silent matcher is aborted; the following job proceeds normally.
        push(24'h515151, 1'b1, 4'h9, 0);
        push(24'h525252, 1'b1, 4'h3, 2);
        drain();
`endif

        // Back-to-back jobs leave exactly two low cycles on m_cs.
        push(24'h303030, 1'b1, 4'h1, 2);
        push(24'h313131, 1'b1, 4'h2, 2);
        push(24'h323232, 1'b0, 4'h3, 2);
        drain();
        chk("cs_gap", 32'(last_gap), 32'd2);

        // Reset in the middle of a long job with two words queued.
        push(24'h414141, 1'b1, 4'h1, 50);
        push(24'h424242, 1'b1, 4'h2, 3);
        push(24'h434343, 1'b1, 4'h3, 3);
        @(negedge clk);
        chk("pre_rst_m_cs",        32'(m_cs),        32'd1);
        chk("pre_rst_queue_count", 32'(queue_count), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_m_cs",        32'(m_cs),        32'd0);
        chk("async_rst_queue_count", 32'(queue_count), 32'd0);
        chk("async_rst_busy",        32'(busy),        32'd0);
        job_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (10) begin
            @(negedge clk);
            saw_valid = saw_valid | rsp_valid | m_cs;
        end
        chk("post_rst_idle", 32'(saw_valid), 32'd0);
        base = n_rsp;
        push(24'h444444, 1'b1, 4'hC, 3);
        drain();
        chk("post_rst_rsp_count", 32'(n_rsp - base), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
